// File: rtl/trace_cmd_dispatcher.sv
// rtl/trace_cmd_dispatcher.sv - buffered in-order dispatcher of trace records to L1/snoop channels and control pulses
// Optional feature macro: DISPATCH_STATS_EN (adds l1_count / snp_count handshake counters)
module trace_cmd_dispatcher #(
  parameter int ADDR_W     = 32,
  parameter int CMD_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CMD_W-1:0]              in_cmd,
  input  logic [ADDR_W-1:0]             in_addr,
  output logic                          l1_valid,
  input  logic                          l1_ready,
  output logic [1:0]                    l1_op,
  output logic [ADDR_W-1:0]             l1_addr,
  output logic                          snp_valid,
  input  logic                          snp_ready,
  output logic [1:0]                    snp_op,
  output logic [ADDR_W-1:0]             snp_addr,
  output logic                          clr_pulse,
  output logic                          prt_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]                   l1_count,
  output logic [31:0]                   snp_count,
`endif
  output logic [15:0]                   bad_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    L1_ISSUE,
    SNP_ISSUE,
    CLR,
    PRT,
    DROP
  } state_t;

  state_t state, next_state;

  logic [CMD_W+ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr, rd_ptr;
  logic [PTR_W:0]          level;
  logic                    full, empty, push, pop, pop_req;

  logic [CMD_W-1:0]        hold_cmd;
  logic [ADDR_W-1:0]       hold_addr;
  logic [CMD_W-1:0]        snp_code;

  // Extra pointer bit distinguishes full from empty; level is their difference.
  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign pop        = pop_req && !empty;
  assign fifo_level = level;

  // Record storage; no reset needed since pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {in_cmd, in_addr};
  end

  // FIFO pointers and the in-flight record register loaded on each pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hold_cmd  <= '0;
      hold_addr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_cmd  <= mem[rd_ptr[PTR_W-1:0]][CMD_W+ADDR_W-1:ADDR_W];
        hold_addr <= mem[rd_ptr[PTR_W-1:0]][ADDR_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; every finishing state may pop the next record directly so issues run every 2 cycles.
  always_comb begin
    next_state = state;
    pop_req    = 1'b0;
    case (state)
      IDLE: begin
        pop_req = 1'b1;
        if (!empty) next_state = DECODE;
      end
      DECODE: begin
        if (hold_cmd <= CMD_W'(2))                                 next_state = L1_ISSUE;
        else if (hold_cmd >= CMD_W'(3) && hold_cmd <= CMD_W'(6))   next_state = SNP_ISSUE;
        else if (hold_cmd == CMD_W'(8))                            next_state = CLR;
        else if (hold_cmd == CMD_W'(9))                            next_state = PRT;
        else                                                       next_state = DROP;
      end
      L1_ISSUE: begin
        if (l1_ready) begin
          pop_req    = 1'b1;
          next_state = empty ? IDLE : DECODE;
        end
      end
      SNP_ISSUE: begin
        if (snp_ready) begin
          pop_req    = 1'b1;
          next_state = empty ? IDLE : DECODE;
        end
      end
      CLR, PRT, DROP: begin
        pop_req    = 1'b1;
        next_state = empty ? IDLE : DECODE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs come straight from state so an async reset drops them immediately; op/addr read 0 when idle.
  assign snp_code  = hold_cmd - CMD_W'(3);
  assign l1_valid  = (state == L1_ISSUE);
  assign snp_valid = (state == SNP_ISSUE);
  assign clr_pulse = (state == CLR);
  assign prt_pulse = (state == PRT);
  assign l1_op     = l1_valid  ? hold_cmd[1:0] : 2'd0;
  assign l1_addr   = l1_valid  ? hold_addr     : '0;
  assign snp_op    = snp_valid ? snp_code[1:0] : 2'd0;
  assign snp_addr  = snp_valid ? hold_addr     : '0;

  // Saturating count of records discarded as illegal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    bad_cnt <= '0;
    else if (state == DROP && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
  end

`ifdef DISPATCH_STATS_EN
  // Accepted-handshake counters per channel, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_count  <= '0;
      snp_count <= '0;
    end else begin
      if (l1_valid && l1_ready)   l1_count  <= l1_count + 32'd1;
      if (snp_valid && snp_ready) snp_count <= snp_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// tb/tb_trace_cmd_dispatcher.sv - directed self-checking bench for trace_cmd_dispatcher
module tb_trace_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_addr = '0;
  logic        l1_valid;
  logic        l1_ready = 1'b0;
  logic [1:0]  l1_op;
  logic [31:0] l1_addr;
  logic        snp_valid;
  logic        snp_ready = 1'b0;
  logic [1:0]  snp_op;
  logic [31:0] snp_addr;
  logic        clr_pulse;
  logic        prt_pulse;
  logic [3:0]  fifo_level;
  logic [15:0] bad_cnt;
`ifdef DISPATCH_STATS_EN
  logic [31:0] l1_count;
  logic [31:0] snp_count;
`endif

  int passed = 0;
  int total  = 0;

  trace_cmd_dispatcher #(.ADDR_W(32), .CMD_W(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .clr_pulse(clr_pulse), .prt_pulse(prt_pulse), .fifo_level(fifo_level),
`ifdef DISPATCH_STATS_EN
    .l1_count(l1_count), .snp_count(snp_count),
`endif
    .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  // Background monitor for the control-pulse scenario.
  logic mon_en = 1'b0;
  int   cyc = 0, clr_n = 0, prt_n = 0, chan_n = 0, clr_at = -1, prt_at = -1;
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (clr_pulse) begin clr_n++; if (clr_at < 0) clr_at = cyc; end
      if (prt_pulse) begin prt_n++; if (prt_at < 0) prt_at = cyc; end
      if (l1_valid || snp_valid) chan_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; record is accepted at the following posedge, returns at the next negedge.
  task automatic push(input logic [3:0] c, input logic [31:0] a);
    total++;
    if (in_ready !== 1'b1) $display("FAIL push_ready: in_ready=%b required 1", in_ready);
    else passed++;
    in_valid = 1'b1; in_cmd = c; in_addr = a;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++; if ({l1_valid, snp_valid, clr_pulse, prt_pulse} !== 4'b0) $display("FAIL rst_valids: got %b required 0000", {l1_valid, snp_valid, clr_pulse, prt_pulse}); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b required 1", in_ready); else passed++;
    total++; if (fifo_level !== 4'd0) $display("FAIL rst_level: got %0d required 0", fifo_level); else passed++;
    total++; if (bad_cnt !== 16'd0) $display("FAIL rst_bad_cnt: got %0d required 0", bad_cnt); else passed++;
    total++; if ({l1_op, snp_op, l1_addr, snp_addr} !== 68'd0) $display("FAIL rst_op_addr: got %h required 0", {l1_op, snp_op, l1_addr, snp_addr}); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_l1_latency();
    l1_ready = 1'b1;
    push(4'd0, 32'h0000_1000);
    total++; if (fifo_level !== 4'd1 || l1_valid !== 1'b0) $display("FAIL lat_n0: level=%0d valid=%b required 1/0", fifo_level, l1_valid); else passed++;
    @(negedge clk);
    total++; if (l1_valid !== 1'b0) $display("FAIL lat_n1: l1_valid=%b required 0", l1_valid); else passed++;
    @(negedge clk);
    total++; if (l1_valid !== 1'b1 || l1_op !== 2'd0 || l1_addr !== 32'h0000_1000) $display("FAIL lat_n2: valid=%b op=%0d addr=%h required 1/0/00001000", l1_valid, l1_op, l1_addr); else passed++;
    @(negedge clk);
    total++; if (l1_valid !== 1'b0) $display("FAIL lat_one_cycle: l1_valid=%b required 0", l1_valid); else passed++;
  endtask

  task automatic test_snoop_stall();
    snp_ready = 1'b0;
    push(4'd6, 32'hABCD_0040);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (snp_valid !== 1'b1 || snp_op !== 2'd3 || snp_addr !== 32'hABCD_0040 || l1_valid !== 1'b0)
        $display("FAIL snp_hold[%0d]: valid=%b op=%0d addr=%h l1=%b required 1/3/abcd0040/0", i, snp_valid, snp_op, snp_addr, l1_valid);
      else passed++;
      @(negedge clk);
    end
    snp_ready = 1'b1;
    @(negedge clk);
    total++; if (snp_valid !== 1'b0) $display("FAIL snp_release: snp_valid=%b required 0", snp_valid); else passed++;
  endtask

  task automatic test_fifo_full();
    int n;
    logic [31:0] a;
    logic [3:0]  c;
    l1_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(4'(i % 3), 32'h100 + 32'(i * 16));
    total++; if (in_ready !== 1'b0 || fifo_level !== 4'd8) $display("FAIL full_state: in_ready=%b level=%0d required 0/8", in_ready, fifo_level); else passed++;
    in_valid = 1'b1; in_cmd = 4'd2; in_addr = 32'hDEAD_BEEF;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    total++; if (fifo_level !== 4'd8) $display("FAIL full_no_push: level=%0d required 8", fifo_level); else passed++;
    l1_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (l1_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      c = 4'(i % 3);
      a = 32'h100 + 32'(i * 16);
      total++;
      if (l1_valid !== 1'b1 || l1_op !== c[1:0] || l1_addr !== a || snp_valid !== 1'b0)
        $display("FAIL drain[%0d]: valid=%b op=%0d addr=%h required 1/%0d/%h", i, l1_valid, l1_op, l1_addr, c[1:0], a);
      else passed++;
      @(negedge clk);
    end
    @(negedge clk); @(negedge clk);
    total++; if (fifo_level !== 4'd0 || l1_valid !== 1'b0) $display("FAIL drain_empty: level=%0d valid=%b required 0/0", fifo_level, l1_valid); else passed++;
  endtask

  task automatic test_ctrl_drop();
    mon_en = 1'b1;
    push(4'd7, 32'h1);
    push(4'd12, 32'h2);
    push(4'd8, 32'h3);
    push(4'd9, 32'h4);
    repeat (12) @(negedge clk);
    mon_en = 1'b0;
    total++; if (bad_cnt !== 16'd2) $display("FAIL bad_cnt: got %0d required 2", bad_cnt); else passed++;
    total++; if (chan_n !== 0) $display("FAIL ctrl_no_channel: valid cycles=%0d required 0", chan_n); else passed++;
    total++; if (clr_n !== 1 || prt_n !== 1) $display("FAIL pulse_width: clr=%0d prt=%0d required 1/1", clr_n, prt_n); else passed++;
    total++; if (!(clr_at > 0 && prt_at > clr_at)) $display("FAIL pulse_order: clr_at=%0d prt_at=%0d required clr before prt", clr_at, prt_at); else passed++;
  endtask

  task automatic test_reset_mid_issue();
    int n;
    l1_ready = 1'b0;
    push(4'd1, 32'h5000);
    push(4'd0, 32'h5010);
    push(4'd2, 32'h5020);
    push(4'd1, 32'h5030);
    n = 0;
    while (l1_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (l1_valid !== 1'b1 || fifo_level !== 4'd3) $display("FAIL pre_rst: valid=%b level=%0d required 1/3", l1_valid, fifo_level); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (l1_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL async_rst: valid=%b level=%0d required 0/0", l1_valid, fifo_level); else passed++;
    @(negedge clk);
    rst = 1'b0;
    l1_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({l1_valid, snp_valid, clr_pulse, prt_pulse} !== 4'b0 || fifo_level !== 4'd0 || in_ready !== 1'b1 || bad_cnt !== 16'd0)
      $display("FAIL post_rst_idle: valids=%b level=%0d in_ready=%b bad=%0d required 0000/0/1/0", {l1_valid, snp_valid, clr_pulse, prt_pulse}, fifo_level, in_ready, bad_cnt);
    else passed++;
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    l1_ready = 1'b1; snp_ready = 1'b1;
    push(4'd0, 32'h10);
    push(4'd3, 32'h20);
    push(4'd1, 32'h30);
    push(4'd5, 32'h40);
    push(4'd2, 32'h50);
    push(4'd8, 32'h60);
    repeat (20) @(negedge clk);
    total++; if (l1_count !== 32'd3) $display("FAIL l1_count: got %0d required 3", l1_count); else passed++;
    total++; if (snp_count !== 32'd2) $display("FAIL snp_count: got %0d required 2", snp_count); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_l1_latency();
    test_snoop_stall();
    test_fifo_full();
    test_ctrl_drop();
    test_reset_mid_issue();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
